mac_lookup_arbiter: RTL and testbench

// Shares the single MAC-table port among the 4 Ethernet receivers. Captures each receiver's
// DA-lookup (new DA) and SA-learn (new SA) requests, arbitrates them round-robin with DA over SA,

---
 rtl/mac_lookup_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mac_lookup_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_lookup_arbiter.sv
// Arbitrates the four receivers' DA-lookup / SA-learn requests onto the single MAC-table port
// and turns each lookup result into a per-port forwarding mask.
module mac_lookup_arbiter #(
  parameter int N_PORTS = 4,
  parameter int KEY_W   = 14,
  parameter int TIMEOUT = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [N_PORTS-1:0]                i_new_da,
  input  logic [N_PORTS-1:0][KEY_W-1:0]     i_da,
  input  logic [N_PORTS-1:0][7:0]           i_da_chk,
  input  logic [N_PORTS-1:0]                i_new_sa,
  input  logic [N_PORTS-1:0][KEY_W-1:0]     i_sa,
  input  logic [N_PORTS-1:0][7:0]           i_sa_chk,
  output logic [N_PORTS-1:0]                o_da_ok,
  output logic                              o_tbl_req,
  output logic                              o_tbl_op,
  output logic [KEY_W-1:0]                  o_tbl_key,
  output logic [7:0]                        o_tbl_chk,
  output logic [1:0]                        o_tbl_port,
  input  logic                              i_tbl_ack,
  input  logic                              i_tbl_hit,
  input  logic [1:0]                        i_tbl_dst,
  output logic [N_PORTS-1:0]                o_fwd_valid,
  output logic [N_PORTS-1:0][N_PORTS-1:0]   o_fwd_mask,
  output logic [15:0]                       o_drop_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  state_t                        state_reg, state_next;
  logic [N_PORTS-1:0]            da_pend, sa_pend, da_rise, sa_rise, da_drop, sa_drop;
  logic [N_PORTS-1:0]            da_grant, sa_grant;
  logic [N_PORTS-1:0][KEY_W-1:0] da_key, sa_key;
  logic [N_PORTS-1:0][7:0]       da_chk, sa_chk;
  logic [1:0]                    da_rr_reg, sa_rr_reg;
  logic [2:0]                    da_pick, sa_pick;
  logic                          op_reg, hit_reg;
  logic [1:0]                    port_reg, dst_reg;
  logic [KEY_W-1:0]              key_reg;
  logic [7:0]                    chk_reg;
  logic [TW-1:0]                 timer_reg;
  logic [15:0]                   drop_cnt_reg;
  logic [16:0]                   drop_sum;
  logic                          load, load_op;
  logic [1:0]                    load_port;
  logic [KEY_W-1:0]              load_key;
  logic [7:0]                    load_chk;
  logic                          resp_lookup;
  logic [N_PORTS-1:0]            port_hot, dst_hot, mask_val;

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [2:0] rr_pick(input logic [N_PORTS-1:0] req, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    logic             da_prev_reg, sa_prev_reg, da_pend_reg, sa_pend_reg;
    logic [KEY_W-1:0] da_key_reg, sa_key_reg;
    logic [7:0]       da_chk_reg, sa_chk_reg;

    assign da_rise[gi] = i_new_da[gi] & ~da_prev_reg;
    assign sa_rise[gi] = i_new_sa[gi] & ~sa_prev_reg;
    // An edge landing on the grant cycle is a fresh request, not an overwrite.
    assign da_drop[gi] = da_rise[gi] & da_pend_reg & ~da_grant[gi];
    assign sa_drop[gi] = sa_rise[gi] & sa_pend_reg & ~sa_grant[gi];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        da_prev_reg <= 1'b0;
        sa_prev_reg <= 1'b0;
        da_pend_reg <= 1'b0;
        sa_pend_reg <= 1'b0;
        da_key_reg  <= '0;
        sa_key_reg  <= '0;
        da_chk_reg  <= '0;
        sa_chk_reg  <= '0;
      end else begin
        da_prev_reg <= i_new_da[gi];
        sa_prev_reg <= i_new_sa[gi];
        da_pend_reg <= (da_pend_reg & ~da_grant[gi]) | da_rise[gi];
        sa_pend_reg <= (sa_pend_reg & ~sa_grant[gi]) | sa_rise[gi];
        if (da_rise[gi]) begin
          da_key_reg <= i_da[gi];
          da_chk_reg <= i_da_chk[gi];
        end
        if (sa_rise[gi]) begin
          sa_key_reg <= i_sa[gi];
          sa_chk_reg <= i_sa_chk[gi];
        end
      end
    end

    assign da_pend[gi]    = da_pend_reg;
    assign sa_pend[gi]    = sa_pend_reg;
    assign da_key[gi]     = da_key_reg;
    assign sa_key[gi]     = sa_key_reg;
    assign da_chk[gi]     = da_chk_reg;
    assign sa_chk[gi]     = sa_chk_reg;
    assign o_fwd_mask[gi] = o_fwd_valid[gi] ? mask_val : '0;
  end

  assign da_pick  = rr_pick(da_pend, da_rr_reg);
  assign sa_pick  = rr_pick(sa_pend, sa_rr_reg);
  assign drop_sum = {1'b0, drop_cnt_reg} + 17'($countones({da_drop, sa_drop}));

  always_comb begin
    state_next = state_reg;
    da_grant   = '0;
    sa_grant   = '0;
    load       = 1'b0;
    load_op    = 1'b0;
    load_port  = '0;
    load_key   = '0;
    load_chk   = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if (da_pick[2]) begin
          da_grant[da_pick[1:0]] = 1'b1;
          load       = 1'b1;
          load_port  = da_pick[1:0];
          load_key   = da_key[da_pick[1:0]];
          load_chk   = da_chk[da_pick[1:0]];
          // Multicast DAs skip the table and flood straight away.
          state_next = da_chk[da_pick[1:0]][0] ? ST_RESP : ST_REQ;
        end else if (sa_pick[2]) begin
          sa_grant[sa_pick[1:0]] = 1'b1;
          load       = 1'b1;
          load_op    = 1'b1;
          load_port  = sa_pick[1:0];
          load_key   = sa_key[sa_pick[1:0]];
          load_chk   = sa_chk[sa_pick[1:0]];
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_tbl_ack || timer_reg == TW'(TIMEOUT - 1)) state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      op_reg       <= 1'b0;
      port_reg     <= '0;
      key_reg      <= '0;
      chk_reg      <= '0;
      hit_reg      <= 1'b0;
      dst_reg      <= '0;
      timer_reg    <= '0;
      da_rr_reg    <= '0;
      sa_rr_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        op_reg    <= load_op;
        port_reg  <= load_port;
        key_reg   <= load_key;
        chk_reg   <= load_chk;
        hit_reg   <= 1'b0;
        timer_reg <= '0;
      end
      if (da_grant != '0) da_rr_reg <= da_pick[1:0] + 2'd1;
      if (sa_grant != '0) sa_rr_reg <= sa_pick[1:0] + 2'd1;
      if (state_reg == ST_REQ) begin
        timer_reg <= timer_reg + TW'(1);
        if (i_tbl_ack) begin
          hit_reg <= i_tbl_hit & ~op_reg;
          dst_reg <= i_tbl_dst;
        end
      end
      drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign resp_lookup = (state_reg == ST_RESP) && !op_reg;
  assign port_hot    = N_PORTS'(1) << port_reg;
  assign dst_hot     = N_PORTS'(1) << dst_reg;
  // Miss floods everywhere but the source; a hit back onto the source port is filtered.
  assign mask_val    = !hit_reg ? ~port_hot : ((dst_reg == port_reg) ? '0 : dst_hot);
  assign o_da_ok     = resp_lookup ? port_hot : '0;
  assign o_fwd_valid = resp_lookup ? port_hot : '0;
  assign o_tbl_req   = (state_reg == ST_REQ);
  assign o_tbl_op    = op_reg;
  assign o_tbl_key   = key_reg;
  assign o_tbl_chk   = chk_reg;
  assign o_tbl_port  = port_reg;
  assign o_drop_cnt  = drop_cnt_reg;
endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Scoreboard bench for mac_lookup_arbiter: table requests and forwarding results are predicted
// when stimulus is driven and compared when the DUT emits them.
`timescale 1ns/1ps
module tb_mac_lookup_arbiter;
  localparam int NP = 4;
  localparam int KW = 14;
  localparam int TO = 32;

  logic                      clk = 1'b0;
  logic                      i_rst;
  logic [NP-1:0]             i_new_da, i_new_sa;
  logic [NP-1:0][KW-1:0]     i_da, i_sa;
  logic [NP-1:0][7:0]        i_da_chk, i_sa_chk;
  logic [NP-1:0]             o_da_ok, o_fwd_valid;
  logic                      o_tbl_req, o_tbl_op;
  logic [KW-1:0]             o_tbl_key;
  logic [7:0]                o_tbl_chk;
  logic [1:0]                o_tbl_port;
  logic                      i_tbl_ack, i_tbl_hit;
  logic [1:0]                i_tbl_dst;
  logic [NP-1:0][NP-1:0]     o_fwd_mask;
  logic [15:0]               o_drop_cnt;

  typedef struct {logic op; int port; int key; int chk; int cyc; int len;} tbl_exp_t;
  typedef struct {int port; int mask; int cyc;} fwd_exp_t;

  tbl_exp_t exp_tbl[$];
  fwd_exp_t exp_fwd[$];
  tbl_exp_t t_got;
  fwd_exp_t f_got;
  int   n_vec = 0, n_err = 0, cyc = 0;
  int   rsp_delay = 2, rcnt = 0;
  logic rsp_hit = 1'b0, spur_ack = 1'b0;
  logic [1:0] rsp_dst = 2'd0;
  logic req_prev = 1'b0;
  int   req_len = 0, cur_len = -1;
  logic [15:0] exp_mask_w;

  mac_lookup_arbiter #(.N_PORTS(NP), .KEY_W(KW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_new_da(i_new_da), .i_da(i_da), .i_da_chk(i_da_chk),
    .i_new_sa(i_new_sa), .i_sa(i_sa), .i_sa_chk(i_sa_chk),
    .o_da_ok(o_da_ok), .o_tbl_req(o_tbl_req), .o_tbl_op(o_tbl_op),
    .o_tbl_key(o_tbl_key), .o_tbl_chk(o_tbl_chk), .o_tbl_port(o_tbl_port),
    .i_tbl_ack(i_tbl_ack), .i_tbl_hit(i_tbl_hit), .i_tbl_dst(i_tbl_dst),
    .o_fwd_valid(o_fwd_valid), .o_fwd_mask(o_fwd_mask), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int fwd_mask(input logic hit, input int dst, input int p);
    if (!hit) return (~(1 << p)) & 15;
    if (dst == p) return 0;
    return 1 << dst;
  endfunction

  // Table model: acks on the rsp_delay-th cycle of a request (0 = never acks).
  always @(negedge clk) begin
    if (o_tbl_req) rcnt++; else rcnt = 0;
    i_tbl_ack = spur_ack | (o_tbl_req && rsp_delay != 0 && rcnt == rsp_delay);
    i_tbl_hit = i_tbl_ack & rsp_hit;
    i_tbl_dst = rsp_dst;
  end

  // Output monitor: pops the scoreboard on every table request and forwarding pulse.
  always @(negedge clk) begin
    if (o_tbl_req && !req_prev) begin
      $display("tbl  cyc=%0d op=%0d port=%0d key=%h chk=%h", cyc, o_tbl_op, o_tbl_port, o_tbl_key, o_tbl_chk);
      if (exp_tbl.size() == 0) begin
        check("tbl_unexpected", 32'd1, 32'd0);
        cur_len = -1;
      end else begin
        t_got = exp_tbl.pop_front();
        check("tbl_op", o_tbl_op, t_got.op);
        check("tbl_port", o_tbl_port, t_got.port);
        check("tbl_key", o_tbl_key, t_got.key);
        check("tbl_chk", o_tbl_chk, t_got.chk);
        if (t_got.cyc >= 0) check("tbl_start_cyc", cyc, t_got.cyc);
        cur_len = t_got.len;
      end
      req_len = 0;
    end
    if (o_tbl_req) req_len++;
    if (!o_tbl_req && req_prev && cur_len >= 0) check("tbl_req_len", req_len, cur_len);
    req_prev = o_tbl_req;

    if (o_fwd_valid != '0) begin
      $display("fwd  cyc=%0d valid=%b ok=%b mask=%h", cyc, o_fwd_valid, o_da_ok, o_fwd_mask);
      if (exp_fwd.size() == 0) begin
        check("fwd_unexpected", {28'd0, o_fwd_valid}, 32'd0);
      end else begin
        f_got = exp_fwd.pop_front();
        exp_mask_w = '0;
        exp_mask_w[f_got.port*4 +: 4] = 4'(f_got.mask);
        check("fwd_valid", o_fwd_valid, 1 << f_got.port);
        check("da_ok", o_da_ok, 1 << f_got.port);
        check("fwd_mask", o_fwd_mask, exp_mask_w);
        if (f_got.cyc >= 0) check("fwd_cyc", cyc, f_got.cyc);
      end
    end else if (o_da_ok != '0) begin
      check("da_ok_unexpected", o_da_ok, 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_all();
    i_new_da = '0;
    i_new_sa = '0;
  endtask

  // Raises port p's DA and predicts its table op and forwarding result.
  task automatic da_req(input int p, input int key, input int chk, input int len,
                        input logic hit, input int dst, input bit timed);
    int c0;
    c0 = cyc;
    i_da[p] = KW'(key);
    i_da_chk[p] = 8'(chk);
    i_new_da[p] = 1'b1;
    if (chk[0]) begin
      exp_fwd.push_back('{p, fwd_mask(1'b0, 0, p), timed ? c0 + 2 : -1});
    end else begin
      exp_tbl.push_back('{1'b0, p, key, chk, timed ? c0 + 2 : -1, len});
      exp_fwd.push_back('{p, fwd_mask(hit, dst, p), timed ? c0 + 2 + len : -1});
    end
  endtask

  task automatic sa_req(input int p, input int key, input int chk, input int len);
    i_sa[p] = KW'(key);
    i_sa_chk[p] = 8'(chk);
    i_new_sa[p] = 1'b1;
    exp_tbl.push_back('{1'b1, p, key, chk, -1, len});
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_tbl.size() != 0 || exp_fwd.size() != 0 || o_tbl_req) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_tbl.size() + exp_fwd.size(), 32'd0);
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    i_new_da = '0; i_new_sa = '0;
    i_da = '0; i_sa = '0; i_da_chk = '0; i_sa_chk = '0;
    tick(3);
    check("rst_tbl_req", o_tbl_req, 32'd0);
    check("rst_da_ok", o_da_ok, 32'd0);
    check("rst_fwd_valid", o_fwd_valid, 32'd0);
    check("rst_fwd_mask", o_fwd_mask, 32'd0);
    check("rst_drop_cnt", o_drop_cnt, 32'd0);
    check("rst_tbl_key", o_tbl_key, 32'd0);
    i_rst = 1'b0;
    tick(2);

    // All four ports at once: round-robin from 0, then again from 0 after wrap.
    rsp_delay = 2; rsp_hit = 1'b1; rsp_dst = 2'd2;
    for (int p = 0; p < NP; p++) da_req(p, 'h100 + p, 2 * p, 2, 1'b1, 2, 1'b0);
    tick(1); release_all();
    drain(200);
    rsp_delay = 3; rsp_hit = 1'b0;
    for (int p = 0; p < NP; p++) da_req(p, 'h200 + p, 4 * p, 3, 1'b0, 0, 1'b0);
    tick(1); release_all();
    drain(200);

    // Single lookup on port 1: request cycles 2-5, result in cycle 6.
    rsp_delay = 4; rsp_hit = 1'b1; rsp_dst = 2'd3;
    da_req(1, 'h0A5, 'h10, 4, 1'b1, 3, 1'b1);
    tick(1); release_all();
    drain(100);

    // DA beats SA raised in the same cycle.
    rsp_delay = 2; rsp_hit = 1'b1; rsp_dst = 2'd0;
    da_req(2, 'h2C3, 'h42, 2, 1'b1, 0, 1'b0);
    sa_req(0, 'h1F7, 'h9A, 2);
    tick(1); release_all();
    drain(100);

    // Multicast DA bypasses the table.
    da_req(3, 'h3AB, 'h01, 0, 1'b0, 0, 1'b1);
    tick(1); release_all();
    drain(100);

    // Stray ack while idle is ignored; a hit back to the source is filtered.
    spur_ack = 1'b1; tick(1); spur_ack = 1'b0; tick(2);
    rsp_delay = 2; rsp_hit = 1'b1; rsp_dst = 2'd3;
    da_req(3, 'h077, 'h00, 2, 1'b1, 3, 1'b1);
    tick(1); release_all();
    drain(100);

    // No ack: request held for the full timeout, then flood.
    rsp_delay = 0;
    da_req(0, 'h1F0, 'h20, TO, 1'b0, 0, 1'b1);
    tick(1); release_all();
    drain(200);

    // Two DA edges on port 2 while busy: one drop, table sees the second key.
    rsp_delay = 0;
    da_req(0, 'h155, 'h08, TO, 1'b0, 0, 1'b0);
    tick(1); release_all();
    tick(5);
    i_da[2] = KW'('h222); i_da_chk[2] = 8'h22; i_new_da[2] = 1'b1;
    tick(1); release_all();
    tick(1);
    i_da[2] = KW'('h333); i_da_chk[2] = 8'h34; i_new_da[2] = 1'b1;
    tick(1); release_all();
    tick(2);
    check("drop_cnt_one", o_drop_cnt, 32'd1);
    rsp_delay = 3; rsp_hit = 1'b1; rsp_dst = 2'd1;
    exp_tbl.push_back('{1'b0, 2, 'h333, 'h34, -1, 3});
    exp_fwd.push_back('{2, fwd_mask(1'b1, 1, 2), -1});
    drain(200);

    // Reset in the middle of a request aborts it with no ack.
    rsp_delay = 0;
    exp_tbl.push_back('{1'b0, 1, 'h0AA, 'h00, cyc + 2, -1});
    i_da[1] = KW'('h0AA); i_da_chk[1] = 8'h00; i_new_da[1] = 1'b1;
    tick(1); release_all();
    tick(5);
    check("pre_rst_req", o_tbl_req, 32'd1);
    i_rst = 1'b1;
    tick(1);
    check("rst_req_drop", o_tbl_req, 32'd0);
    check("rst_no_da_ok", o_da_ok, 32'd0);
    check("rst_drop_clr", o_drop_cnt, 32'd0);
    i_rst = 1'b0;
    tick(40);
    check("post_rst_queues", exp_tbl.size() + exp_fwd.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
